// File: rtl/punto_fijo_pkg.sv
// Shared fixed-point definitions for the filter blocks: default formats,
// rounding mode, rounding constant and symmetric saturation limits.
package punto_fijo_pkg;

  localparam int DEF_WIDTH     = 25;
  localparam int DEF_PRESICION = 16;
  localparam int DEF_ACC_GUARD = 8;

  // Wide enough for any accumulator this library builds; callers cast down.
  localparam int PF_MAX_W = 128;
  typedef logic signed [PF_MAX_W-1:0] pf_ancho_t;

  typedef enum logic {
    TRUNCAR   = 1'b0,
    REDONDEAR = 1'b1
  } modo_redondeo_e;

  // Largest positive result: 2**(width-1)-1.
  function automatic pf_ancho_t sat_max(input int width);
    return (pf_ancho_t'(1) <<< (width - 1)) - pf_ancho_t'(1);
  endfunction

  // Symmetric range: the most negative code is never produced.
  function automatic pf_ancho_t sat_min(input int width);
    return -sat_max(width);
  endfunction

  function automatic pf_ancho_t rnd_const(input int presicion, input modo_redondeo_e modo);
    if (modo == REDONDEAR && presicion > 0)
      return pf_ancho_t'(1) <<< (presicion - 1);
    return '0;
  endfunction

endpackage

// File: rtl/mac_saturado_if.sv
// Beat-in / result-out bundle of the saturating MAC.
interface mac_saturado_if
  import punto_fijo_pkg::*;
#(
  parameter int Width = DEF_WIDTH
);
  logic                    in_valid;
  logic                    in_last;
  logic signed [Width-1:0] A;
  logic signed [Width-1:0] B;
  logic                    out_valid;
  logic signed [Width-1:0] Y;
  logic                    sat;

  modport master (
    output in_valid, in_last, A, B,
    input  out_valid, Y, sat
  );

  modport slave (
    input  in_valid, in_last, A, B,
    output out_valid, Y, sat
  );
endinterface

// File: rtl/redondeo_saturacion.sv
// Combinational round / arithmetic right shift / symmetric clamp of a wide
// accumulator down to a Width-bit result with Presicion fractional bits.
module redondeo_saturacion
  import punto_fijo_pkg::*;
#(
  parameter int InW       = 2 * DEF_WIDTH + DEF_ACC_GUARD,
  parameter int Width     = DEF_WIDTH,
  parameter int Presicion = DEF_PRESICION,
  parameter int Redondeo  = 1
) (
  input  logic signed [InW-1:0]   acc,
  output logic signed [Width-1:0] y,
  output logic                    sat
);

  // One spare bit so adding the rounding constant can never wrap.
  localparam int SUM_W = InW + 1;
  localparam modo_redondeo_e MODO = modo_redondeo_e'(Redondeo != 0);
  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(rnd_const(Presicion, MODO));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(sat_max(Width));
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(sat_min(Width));

  logic signed [SUM_W-1:0] desplazado;
  logic signed [Width-1:0] y_c;
  logic                    sat_c;

  function automatic logic signed [SUM_W-1:0] redondear(input logic signed [InW-1:0] v);
    logic signed [SUM_W-1:0] ext;
    ext = SUM_W'(v);
    return (ext + RND) >>> Presicion;
  endfunction

  function automatic logic saturar(input  logic signed [SUM_W-1:0] v,
                                   output logic signed [Width-1:0] yo);
    if (v > SAT_MAX) begin
      yo = SAT_MAX[Width-1:0];
      return 1'b1;
    end
    if (v < SAT_MIN) begin
      yo = SAT_MIN[Width-1:0];
      return 1'b1;
    end
    yo = v[Width-1:0];
    return 1'b0;
  endfunction

  always_comb begin
    desplazado = '0;
    y_c        = '0;
    sat_c      = 1'b0;
    desplazado = redondear(acc);
    sat_c      = saturar(desplazado, y_c);
  end

  assign y   = y_c;
  assign sat = sat_c;

endmodule

// File: rtl/mac_saturado.sv
// Packetised signed multiply-accumulate with rounding and symmetric
// saturation; one result pulse per packet, four cycles after its last beat.
module mac_saturado
  import punto_fijo_pkg::*;
#(
  parameter int Width     = DEF_WIDTH,
  parameter int Presicion = DEF_PRESICION,
  parameter int AccGuard  = DEF_ACC_GUARD,
  parameter int Redondeo  = 1
) (
  input  logic           clk,
  input  logic           reset,
  mac_saturado_if.slave  bus
);

  localparam int PROD_W = 2 * Width;
  localparam int ACC_W  = PROD_W + AccGuard;

  logic signed [Width-1:0]  a_p0, b_p0;
  logic                     vld_p0, last_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1, last_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic                     vld_p2;
  logic                     primero;
  logic signed [Width-1:0]  y_p3;
  logic                     sat_p3, vld_p3;

  logic signed [Width-1:0]  y_rs;
  logic                     sat_rs;

  redondeo_saturacion #(
    .InW       (ACC_W),
    .Width     (Width),
    .Presicion (Presicion),
    .Redondeo  (Redondeo)
  ) u_redondeo_saturacion (
    .acc (acc_p2),
    .y   (y_rs),
    .sat (sat_rs)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_p0    <= '0;
      b_p0    <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      acc_p2  <= '0;
      vld_p2  <= 1'b0;
      primero <= 1'b1;
      y_p3    <= '0;
      sat_p3  <= 1'b0;
      vld_p3  <= 1'b0;
    end else begin
      // p0: operand capture
      vld_p0  <= bus.in_valid;
      last_p0 <= bus.in_valid & bus.in_last;
      if (bus.in_valid) begin
        a_p0 <= bus.A;
        b_p0 <= bus.B;
      end
      // p1: full-width product
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      if (vld_p0)
        prod_p1 <= PROD_W'(a_p0) * PROD_W'(b_p0);
      // p2: accumulate; first beat of a packet loads instead of adding
      vld_p2 <= vld_p1 & last_p1;
      if (vld_p1) begin
        acc_p2  <= primero ? ACC_W'(prod_p1) : acc_p2 + ACC_W'(prod_p1);
        primero <= last_p1;
      end
      // p3: rounded, clamped result held until the next packet completes
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        y_p3   <= y_rs;
        sat_p3 <= sat_rs;
      end
    end
  end

  assign bus.out_valid = vld_p3;
  assign bus.Y         = y_p3;
  assign bus.sat       = sat_p3;

endmodule

// File: doc/mac_saturado.md
MAC_SATURADO -- requirements
Module: mac_saturado

Interface
REQ-001 SHALL have parameter Width, default 25, total bits of signed fixed-point operands and result.
REQ-002 SHALL have parameter Presicion, default 16, fractional bits of operands and result.
REQ-003 SHALL have parameter AccGuard, default 8, extra accumulator bits; exact sums for packets up to 2**AccGuard beats.
REQ-004 SHALL have parameter Redondeo, default 1: 1 = round half up (toward +inf), 0 = truncate (floor).
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  A/B beat present this cycle.
REQ-008 SHALL have port in_last  input  1  qualifies the final beat of a packet; ignored when in_valid=0.
REQ-009 SHALL have port A  input  Width  signed operand.
REQ-010 SHALL have port B  input  Width  signed operand.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse; Y and sat are valid.
REQ-012 SHALL have port Y  output  Width  signed, rounded, saturated sum of products of the packet.
REQ-013 SHALL have port sat  output  1  Y was clamped; qualified by out_valid.

Function
REQ-014 SHALL accept one beat per cycle; no backpressure; in_valid=0 gaps inside a packet SHALL leave the accumulator unchanged.
REQ-015 Stage 1 SHALL register the full 2*Width-bit signed product A*B with its valid/last flags.
REQ-016 Stage 2 SHALL add the product to a (2*Width+AccGuard)-bit accumulator, which loads the product instead of adding when it is the first beat of a packet.
REQ-017 The first-beat flag SHALL be set by reset and by every accepted last beat, and cleared by every accepted non-last beat.
REQ-018 Stage 3 SHALL, on a last beat, form acc + (Redondeo ? 2**(Presicion-1) : 0), then arithmetic-shift it right by Presicion.
REQ-019 If the shifted value > 2**(Width-1)-1, Stage 3 SHALL output Y = 2**(Width-1)-1 with sat=1.
REQ-020 If the shifted value < -(2**(Width-1)-1), Stage 3 SHALL output Y = -(2**(Width-1)-1) (symmetric range) with sat=1.
REQ-021 Otherwise Stage 3 SHALL output Y = the low Width bits of the shifted value with sat=0.
REQ-022 Latency: last beat sampled at edge n SHALL give out_valid=1 with Y/sat in the cycle after edge n+3.
REQ-023 Back-to-back packets, including single-beat packets every cycle, SHALL produce one out_valid per packet, with no residue between packets.
REQ-024 Y and sat SHALL hold their last value while out_valid=0.
REQ-025 Packets longer than 2**AccGuard beats are unsupported; the result is unspecified.

Reset
REQ-026 reset low SHALL asynchronously clear all pipeline registers, the accumulator, out_valid, Y and sat to 0, and set the first-beat flag to 1.
REQ-027 Reset asserted mid-packet SHALL discard the partial sum; the first beat after release SHALL start a new packet.

Structure
REQ-028 Saturation limits, the rounding constant and default Width/Presicion SHALL live in shared package punto_fijo_pkg, used by the filter blocks.
REQ-029 Stage-3 round/shift/clamp logic SHALL be one combinational sub-module, redondeo_saturacion, parameterised by input width, Width, Presicion and Redondeo.

Verification (Width=25, Presicion=16; 1.0 = 65536)
REQ-030 Single beat, last: A=98304, B=131072 -> Y=196608, sat=0, 4 cycles later.
REQ-031 4-beat packet, A=B=32768 each with one idle gap -> single out_valid, Y=65536, sat=0.
REQ-032 A=13107200, B=131072 -> Y=16777215, sat=1; then A=-13107200, B=131072 -> Y=-16777215, sat=1.
REQ-033 A=1, B=32768: Redondeo=1 -> Y=1; Redondeo=0 -> Y=0; A=-1, B=32768: Redondeo=1 -> Y=0; Redondeo=0 -> Y=-1.
REQ-034 8 consecutive single-beat packets A=k*65536, B=65536 (k=1..8) -> 8 consecutive out_valid cycles, Y=k*65536.
REQ-035 Reset pulse after 2 beats of a packet, then single beat A=B=65536 last -> Y=65536, and no out_valid for the aborted packet.
